exc_controller: RTL and testbench
=================================

Name: exc_controller

Overview:
- Exception source for the LEGv8 single-cycle datapath; drives the far end of the Exc/EStatus/ExcAck/ERet handshake.
- Collects four external interrupt lines plus two internal faults (invalid opcode from decode, misaligned data-memory access) into sticky pending bits.
- Prioritises pending causes and raises Exc with a 4-bit EStatus cause code.
- Holds the request until ExcAck, then blocks new requests until the handler executes ERet.

Parameters:
N, 64, data-memory address width (matches datapath DM_addr).
ALIGN_BITS, 3, low DM_addr bits that must be zero on any enabled data access (3 = 8-byte doubleword).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
irq  input  4  external interrupt requests, asynchronous to clk, level.
irq_mask  input  4  1 = IRQ i enabled for raising; pending still recorded when 0.
invalid_op  input  1  decode flags current instruction as undefined (synchronous, valid at edge).
DM_addr  input  N  data-memory address from datapath.
DM_readEnable  input  1  data read this cycle.
DM_writeEnable  input  1  data write this cycle.
ExcAck  input  1  datapath has taken the exception.
ERet  input  1  datapath executing ERET.
Exc  output  1  exception request, registered.
EStatus  output  4  cause code, registered.
in_handler  output  1  high while state = HANDLER.
pending  output  6  {irq_pend[3:0], misalign_pend, invop_pend}, registered.

Behaviour:
- Reset (reset=0, async): state=IDLE; Exc=0, EStatus=4'b0000, in_handler=0, pending=0; synchronizer and edge-detect flops=0.
- IRQ path:
  - Each irq[i] passes through a 2-flop synchronizer plus a previous-value flop.
  - A rising edge of the synchronized signal sets irq_pend[i].
  - Latency from irq rise to pending bit is 3 clk edges.
  - A held-high level does not re-pend.
- Fault path, sampled at each edge:
  - invalid_op=1 sets invop_pend.
  - (DM_readEnable|DM_writeEnable) && DM_addr[ALIGN_BITS-1:0]!=0 sets misalign_pend.
  - Faults are imprecise: reported after the faulting instruction retires.
- Eligible causes: invop_pend, misalign_pend, and irq_pend[i]&irq_mask[i].
- Priority, highest first, with codes:
  - invop: 4'b0001
  - misalign: 4'b0010
  - irq0: 4'b1000
  - irq1: 4'b1001
  - irq2: 4'b1010
  - irq3: 4'b1011
- FSM IDLE:
  - If any cause is eligible at an edge → RAISE.
  - At the same edge, Exc←1 and EStatus←code of the highest-priority eligible cause.
  - Otherwise Exc=0 and EStatus=0.
- FSM RAISE:
  - Exc and EStatus held stable; the cause code is frozen even if a higher-priority cause arrives.
  - ExcAck=1 at an edge → HANDLER: Exc←0, EStatus holds the cause, the acknowledged cause's pending bit is cleared.
  - ERet is ignored in RAISE.
- FSM HANDLER:
  - in_handler=1, Exc=0, EStatus holds the acknowledged cause (readable by the handler).
  - New events still set pending bits.
  - ERet=1 at an edge → IDLE and EStatus←0.
  - ExcAck is ignored in HANDLER.
- Back-to-back causes: after ERet, at least one IDLE cycle passes before the next Exc, so Exc is never high on the edge that leaves HANDLER.
- Set/clear collision: if a pending bit is cleared by ack and its source fires on the same edge, the bit stays set (set wins).
- ExcAck in IDLE is ignored. Both ExcAck and ERet high in RAISE: ack honoured, ERet ignored.
- Mask change while in RAISE does not withdraw the request.
- Reset asserted in any state returns everything to reset values immediately; pending events are lost.

Test Plan:
1. Reset, then irq[2] 0→1 held, irq_mask=4'hF → pending[4]=1 after 3 edges; Exc=1, EStatus=4'b1010 on the next edge; ExcAck pulse → Exc=0, in_handler=1, pending[4]=0; ERet pulse → in_handler=0, EStatus=0; no second Exc while irq[2] stays high.
2. Same edge: invalid_op=1, DM_writeEnable=1 with DM_addr=64'h1004, irq[0] pending → EStatus=4'b0001. After ack+ERet, next EStatus=4'b0010. After ack+ERet, next EStatus=4'b1000.
3. irq_mask=4'b0000, pulse irq[1] → pending[3]=1, Exc stays 0. Set irq_mask[1]=1 → Exc=1, EStatus=4'b1001 on the next edge.
4. In RAISE with EStatus=4'b1001, assert invalid_op → EStatus stays 4'b1001 until ack. After ERet, invop is raised with code 4'b0001.
5. Aligned access DM_addr=64'h1008 with DM_readEnable=1 → no misalign_pend. Misaligned address with both enables 0 → no misalign_pend.
6. Drive reset=0 mid-RAISE, asynchronously between edges → Exc, EStatus, pending and in_handler go to 0 immediately. After release with no inputs active, Exc stays 0.

Source files
------------

// File: rtl/exc_controller.sv
// Exception controller for the LEGv8 single-cycle datapath.
// It merges four external interrupt lines and two internal faults into sticky
// pending bits. It raises Exc with a prioritised cause code and holds it until
// ExcAck. No new request is raised until the handler executes ERet.
module exc_controller #(
   parameter int N          = 64,
   parameter int ALIGN_BITS = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [3:0]   irq,
   input  logic [3:0]   irq_mask,
   input  logic         invalid_op,
   input  logic [N-1:0] DM_addr,
   input  logic         DM_readEnable,
   input  logic         DM_writeEnable,
   input  logic         ExcAck,
   input  logic         ERet,
   output logic         Exc,
   output logic [3:0]   EStatus,
   output logic         in_handler,
   output logic [5:0]   pending
);

   // Bit positions inside the pending vector
   localparam int INVOP_BIT    = 0;
   localparam int MISALIGN_BIT = 1;
   localparam int IRQ_BASE     = 2;

   // Cause codes reported on EStatus
   localparam logic [3:0] CODE_NONE     = 4'b0000;
   localparam logic [3:0] CODE_INVOP    = 4'b0001;
   localparam logic [3:0] CODE_MISALIGN = 4'b0010;
   localparam logic [3:0] CODE_IRQ0     = 4'b1000;
   localparam logic [3:0] CODE_IRQ1     = 4'b1001;
   localparam logic [3:0] CODE_IRQ2     = 4'b1010;
   localparam logic [3:0] CODE_IRQ3     = 4'b1011;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RAISE   = 2'b01,
      HANDLER = 2'b10
   } state_t;

   state_t     state;
   state_t     next_state;
   logic       next_exc;
   logic [3:0] next_estatus;

   logic [3:0] irq_sync1;
   logic [3:0] irq_sync2;
   logic [3:0] irq_prev;
   logic [3:0] irq_rise;

   logic       misalign_hit;
   logic [5:0] set_vec;
   logic [5:0] clear_vec;
   logic [5:0] eligible;
   logic       any_eligible;
   logic [3:0] top_code;

   // The address bits above the alignment field are never used here
   logic       unused_addr_hi;
   assign unused_addr_hi = ^DM_addr[N-1:ALIGN_BITS];

   // Map a cause code back to its one-hot pending bit, so that an
   // acknowledge clears exactly the cause that was reported.
   function automatic logic [5:0] cause_onehot(input logic [3:0] code);
      logic [5:0] result;
      result = '0;
      case (code)
         CODE_INVOP:    result[INVOP_BIT]    = 1'b1;
         CODE_MISALIGN: result[MISALIGN_BIT] = 1'b1;
         CODE_IRQ0:     result[IRQ_BASE + 0] = 1'b1;
         CODE_IRQ1:     result[IRQ_BASE + 1] = 1'b1;
         CODE_IRQ2:     result[IRQ_BASE + 2] = 1'b1;
         CODE_IRQ3:     result[IRQ_BASE + 3] = 1'b1;
         default:       result = '0;
      endcase
      return result;
   endfunction

   // Two-flop synchronizer for the asynchronous irq lines, plus a
   // previous-value flop for rising-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_sync1 <= '0;
         irq_sync2 <= '0;
         irq_prev  <= '0;
      end else begin
         irq_sync1 <= irq;
         irq_sync2 <= irq_sync1;
         irq_prev  <= irq_sync2;
      end
   end

   assign irq_rise = irq_sync2 & ~irq_prev;

   // A data access is misaligned when any low address bit is set while
   // a read or write is enabled. With no access the address is ignored.
   assign misalign_hit = (DM_readEnable | DM_writeEnable) &&
                         (DM_addr[ALIGN_BITS-1:0] != '0);

   assign set_vec = {irq_rise, misalign_hit, invalid_op};

   // Faults are always eligible. Interrupts are eligible only when unmasked,
   // but a masked interrupt stays pending.
   assign eligible     = {pending[5:2] & irq_mask, pending[MISALIGN_BIT], pending[INVOP_BIT]};
   assign any_eligible = |eligible;

   // Fixed-priority select: invop, then misalign, then irq0..irq3
   always_comb begin
      top_code = CODE_NONE;
      if (eligible[INVOP_BIT])
         top_code = CODE_INVOP;
      else if (eligible[MISALIGN_BIT])
         top_code = CODE_MISALIGN;
      else if (eligible[IRQ_BASE + 0])
         top_code = CODE_IRQ0;
      else if (eligible[IRQ_BASE + 1])
         top_code = CODE_IRQ1;
      else if (eligible[IRQ_BASE + 2])
         top_code = CODE_IRQ2;
      else if (eligible[IRQ_BASE + 3])
         top_code = CODE_IRQ3;
   end

   // Sticky pending bits. If a set and an acknowledge clear hit the same
   // bit on the same edge, the set wins so that no event is lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         pending <= '0;
      else
         pending <= (pending & ~clear_vec) | set_vec;
   end

   // Registers for the state, the request and the cause code
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         Exc     <= 1'b0;
         EStatus <= CODE_NONE;
      end else begin
         state   <= next_state;
         Exc     <= next_exc;
         EStatus <= next_estatus;
      end
   end

   // Next state, next request, next cause code and the acknowledge clear.
   // The cause code is frozen in RAISE and HANDLER. Leaving HANDLER always
   // passes through one IDLE cycle before the next request.
   always_comb begin
      next_state   = state;
      next_exc     = Exc;
      next_estatus = EStatus;
      clear_vec    = '0;
      case (state)
         IDLE: begin
            if (any_eligible) begin
               next_state   = RAISE;
               next_exc     = 1'b1;
               next_estatus = top_code;
            end else begin
               next_exc     = 1'b0;
               next_estatus = CODE_NONE;
            end
         end
         RAISE: begin
            if (ExcAck) begin
               next_state = HANDLER;
               next_exc   = 1'b0;
               clear_vec  = cause_onehot(EStatus);
            end
         end
         HANDLER: begin
            next_exc = 1'b0;
            if (ERet) begin
               next_state   = IDLE;
               next_estatus = CODE_NONE;
            end
         end
         default: begin
            next_state   = IDLE;
            next_exc     = 1'b0;
            next_estatus = CODE_NONE;
         end
      endcase
   end

   assign in_handler = (state == HANDLER);

endmodule

// File: tb/tb_exc_controller.sv
// Directed self-checking bench for exc_controller.
// Inputs change 1 ns after each rising edge, and outputs are checked there.
module tb_exc_controller;

   logic        clk;
   logic        reset;
   logic [3:0]  irq;
   logic [3:0]  irq_mask;
   logic        invalid_op;
   logic [63:0] DM_addr;
   logic        DM_readEnable;
   logic        DM_writeEnable;
   logic        ExcAck;
   logic        ERet;
   logic        Exc;
   logic [3:0]  EStatus;
   logic        in_handler;
   logic [5:0]  pending;

   int assertion_count = 0;
   int fail_count      = 0;

   exc_controller #(.N(64), .ALIGN_BITS(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .irq            (irq),
      .irq_mask       (irq_mask),
      .invalid_op     (invalid_op),
      .DM_addr        (DM_addr),
      .DM_readEnable  (DM_readEnable),
      .DM_writeEnable (DM_writeEnable),
      .ExcAck         (ExcAck),
      .ERet           (ERet),
      .Exc            (Exc),
      .EStatus        (EStatus),
      .in_handler     (in_handler),
      .pending        (pending)
   );

   // 10 ns clock with rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge, then move 1 ns away from it
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      assertion_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Check every output at once
   task automatic check_all(input string tag, input logic exp_exc, input logic [3:0] exp_status,
                            input logic exp_handler, input logic [5:0] exp_pending);
      check_output({tag, ".Exc"},        {7'd0, Exc},        {7'd0, exp_exc});
      check_output({tag, ".EStatus"},    {4'd0, EStatus},    {4'd0, exp_status});
      check_output({tag, ".in_handler"}, {7'd0, in_handler}, {7'd0, exp_handler});
      check_output({tag, ".pending"},    {2'd0, pending},    {2'd0, exp_pending});
   endtask

   task automatic ack_pulse();
      ExcAck = 1'b1;
      step(1);
      ExcAck = 1'b0;
   endtask

   task automatic eret_pulse();
      ERet = 1'b1;
      step(1);
      ERet = 1'b0;
   endtask

   initial begin
      reset          = 1'b0;
      irq            = 4'h0;
      irq_mask       = 4'hF;
      invalid_op     = 1'b0;
      DM_addr        = 64'h0;
      DM_readEnable  = 1'b0;
      DM_writeEnable = 1'b0;
      ExcAck         = 1'b0;
      ERet           = 1'b0;

      // Reset values
      step(2);
      check_all("reset", 1'b0, 4'b0000, 1'b0, 6'b000000);
      reset = 1'b1;
      step(1);
      check_all("after_release", 1'b0, 4'b0000, 1'b0, 6'b000000);

      // Test 1: irq2 raised and held
      irq = 4'b0100;
      step(2);
      check_output("t1.pend_edge2", {2'd0, pending}, 8'h00);
      step(1);
      check_all("t1.pend_edge3", 1'b0, 4'b0000, 1'b0, 6'b010000);
      step(1);
      check_all("t1.raise", 1'b1, 4'b1010, 1'b0, 6'b010000);
      step(1);
      check_all("t1.hold", 1'b1, 4'b1010, 1'b0, 6'b010000);
      ack_pulse();
      check_all("t1.ack", 1'b0, 4'b1010, 1'b1, 6'b000000);
      step(1);
      check_all("t1.handler_ackign", 1'b0, 4'b1010, 1'b1, 6'b000000);
      eret_pulse();
      check_all("t1.eret", 1'b0, 4'b0000, 1'b0, 6'b000000);
      step(3);
      check_all("t1.no_repend", 1'b0, 4'b0000, 1'b0, 6'b000000);
      irq = 4'b0000;
      step(3);

      // Test 2: invop, misalign and irq0 become pending on the same edge
      irq = 4'b0001;
      step(2);
      invalid_op     = 1'b1;
      DM_writeEnable = 1'b1;
      DM_addr        = 64'h1004;
      step(1);
      invalid_op     = 1'b0;
      DM_writeEnable = 1'b0;
      check_all("t2.all_pend", 1'b0, 4'b0000, 1'b0, 6'b000111);
      step(1);
      check_all("t2.raise_invop", 1'b1, 4'b0001, 1'b0, 6'b000111);
      ack_pulse();
      check_all("t2.ack_invop", 1'b0, 4'b0001, 1'b1, 6'b000110);
      eret_pulse();
      check_output("t2.gap_exc", {7'd0, Exc}, 8'h00);
      step(1);
      check_all("t2.raise_misalign", 1'b1, 4'b0010, 1'b0, 6'b000110);
      ack_pulse();
      eret_pulse();
      step(1);
      check_all("t2.raise_irq0", 1'b1, 4'b1000, 1'b0, 6'b000100);
      ack_pulse();
      eret_pulse();
      irq = 4'b0000;
      step(3);
      check_all("t2.quiet", 1'b0, 4'b0000, 1'b0, 6'b000000);

      // Test 3: a masked irq1 stays pending until unmasked
      irq_mask = 4'b0000;
      irq      = 4'b0010;
      step(2);
      irq      = 4'b0000;
      step(3);
      check_all("t3.masked", 1'b0, 4'b0000, 1'b0, 6'b001000);
      irq_mask = 4'b0010;
      step(1);
      check_all("t3.unmask_raise", 1'b1, 4'b1001, 1'b0, 6'b001000);

      // Test 4: a higher-priority fault in RAISE does not change the code;
      // ERet in RAISE is ignored
      invalid_op = 1'b1;
      step(1);
      invalid_op = 1'b0;
      check_all("t4.frozen", 1'b1, 4'b1001, 1'b0, 6'b001001);
      eret_pulse();
      check_all("t4.eret_ignored", 1'b1, 4'b1001, 1'b0, 6'b001001);
      irq_mask = 4'b0000;
      step(1);
      check_output("t4.mask_no_withdraw", {7'd0, Exc}, 8'h01);
      ack_pulse();
      check_all("t4.ack_irq1", 1'b0, 4'b1001, 1'b1, 6'b000001);
      eret_pulse();
      step(1);
      check_all("t4.raise_invop", 1'b1, 4'b0001, 1'b0, 6'b000001);
      // Ack, ERet and a new invalid_op on the same edge: the ack wins over
      // ERet, and the set wins over the clear
      ExcAck     = 1'b1;
      ERet       = 1'b1;
      invalid_op = 1'b1;
      step(1);
      ExcAck     = 1'b0;
      ERet       = 1'b0;
      invalid_op = 1'b0;
      check_all("t4.collision", 1'b0, 4'b0001, 1'b1, 6'b000001);
      eret_pulse();
      step(1);
      check_all("t4.reraise_invop", 1'b1, 4'b0001, 1'b0, 6'b000001);
      ack_pulse();
      eret_pulse();
      check_all("t4.clean", 1'b0, 4'b0000, 1'b0, 6'b000000);
      irq_mask = 4'hF;

      // Test 5: an aligned access, and a misaligned address with no access
      DM_addr       = 64'h1008;
      DM_readEnable = 1'b1;
      step(1);
      DM_readEnable = 1'b0;
      check_output("t5.aligned", {2'd0, pending}, 8'h00);
      DM_addr = 64'h1003;
      step(1);
      check_output("t5.no_access", {2'd0, pending}, 8'h00);
      DM_addr        = 64'h1003;
      DM_writeEnable = 1'b0;
      DM_readEnable  = 1'b1;
      step(1);
      DM_readEnable  = 1'b0;
      check_output("t5.misaligned_read", {2'd0, pending}, 8'h02);
      step(1);
      check_all("t5.raise_misalign", 1'b1, 4'b0010, 1'b0, 6'b000010);

      // Test 6: asynchronous reset in the middle of RAISE
      irq = 4'b1000;
      step(1);
      #2;
      reset = 1'b0;
      #1;
      check_all("t6.async_reset", 1'b0, 4'b0000, 1'b0, 6'b000000);
      irq = 4'b0000;
      step(2);
      reset = 1'b1;
      step(4);
      check_all("t6.post_reset", 1'b0, 4'b0000, 1'b0, 6'b000000);

      $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, fail_count);
      $finish;
   end

endmodule
